ps2_direction_decoder: RTL and testbench



---
 rtl/ps2_pkg.sv | 84 ++++++++
 rtl/ps2_rx_frame.sv | 125 ++++++++++++
 rtl/ps2_direction_decoder.sv | 100 ++++++++++
 tb/tb_ps2_direction_decoder.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared types and constants for the PS/2 direction decoder.
//   * receiver FSM state enum
//   * 2-bit direction encodings and keys_held bit positions
//   * scan code constants (prefixes, arrow keys, WASD)
//   * map_dir(): scan code -> direction lookup
// Build option: define PS2_WASD_EN to let non-extended W/A/S/D codes drive
// the direction outputs alongside the arrow keys.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_e;

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_RIGHT = 2'b01;
   localparam logic [1:0] DIR_DOWN  = 2'b10;
   localparam logic [1:0] DIR_LEFT  = 2'b11;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_A     = 8'h1C;

   localparam int KEY_UP_BIT    = 3;
   localparam int KEY_RIGHT_BIT = 2;
   localparam int KEY_DOWN_BIT  = 1;
   localparam int KEY_LEFT_BIT  = 0;

   typedef struct packed {
      logic       hit;
      logic [1:0] code;
   } dir_map_t;

   // Arrow keys only count when E0-prefixed; the same codes without the
   // prefix are keypad keys and are ignored.
   function automatic dir_map_t map_dir(input logic ext, input logic [7:0] code);
      dir_map_t m;
      m.hit  = 1'b0;
      m.code = DIR_UP;
      if (ext) begin
         case (code)
            SC_UP:    begin m.hit = 1'b1; m.code = DIR_UP;    end
            SC_RIGHT: begin m.hit = 1'b1; m.code = DIR_RIGHT; end
            SC_DOWN:  begin m.hit = 1'b1; m.code = DIR_DOWN;  end
            SC_LEFT:  begin m.hit = 1'b1; m.code = DIR_LEFT;  end
            default:  ;
         endcase
      end
`ifdef PS2_WASD_EN
      else begin
         case (code)
            SC_W:    begin m.hit = 1'b1; m.code = DIR_UP;    end
            SC_D:    begin m.hit = 1'b1; m.code = DIR_RIGHT; end
            SC_S:    begin m.hit = 1'b1; m.code = DIR_DOWN;  end
            SC_A:    begin m.hit = 1'b1; m.code = DIR_LEFT;  end
            default: ;
         endcase
      end
`endif
      return m;
   endfunction

   function automatic logic [3:0] key_mask(input logic [1:0] d);
      logic [3:0] m;
      m = 4'b0000;
      case (d)
         DIR_UP:    m[KEY_UP_BIT]    = 1'b1;
         DIR_RIGHT: m[KEY_RIGHT_BIT] = 1'b1;
         DIR_DOWN:  m[KEY_DOWN_BIT]  = 1'b1;
         default:   m[KEY_LEFT_BIT]  = 1'b1;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame -- PS/2 frame receiver.
// Synchronises and de-glitches the raw PS/2 clock, samples data on filtered
// falling edges, checks odd parity and the stop bit, and abandons partial
// frames after a quiet period.
// Ports:
//   clk_pixel, rst_n      clock / async active-low reset
//   ps2_clk, ps2_data     raw asynchronous keyboard pins
//   rx_byte               received byte (valid with byte_valid)
//   byte_valid            pulse in the cycle a good stop bit is sampled
//   frame_err             pulse on parity/stop error or timeout
//
// state  | meaning
// IDLE   | waiting for a start bit (data low on a falling edge)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | sampling the odd-parity bit
// STOP   | sampling the stop bit, then back to IDLE
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int C_filter_len     = 8,
   parameter int C_timeout_cycles = 5000
) (
   input  logic       clk_pixel,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int TW = $clog2(C_timeout_cycles + 1);
   localparam logic [3:0]    FLT_LOAD = 4'(C_filter_len - 1);
   localparam logic [TW-1:0] TMO_LOAD = TW'(C_timeout_cycles - 1);

   logic          clk_meta, clk_sync, data_meta, data_sync;
   logic          clk_f, clk_f_d;
   logic [3:0]    flt_cnt;
   logic          fall;
   ps2_state_e    state;
   logic [2:0]    bit_cnt;
   logic [7:0]    sr;
   logic          par_ok;
   logic [TW-1:0] tmo_cnt;
   logic          timeout;

   // Everything on the input side resets high so releasing reset never
   // looks like a falling edge.
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         clk_meta  <= 1'b1;
         clk_sync  <= 1'b1;
         data_meta <= 1'b1;
         data_sync <= 1'b1;
         clk_f     <= 1'b1;
         clk_f_d   <= 1'b1;
         flt_cnt   <= 4'd0;
      end else begin
         clk_meta  <= ps2_clk;
         clk_sync  <= clk_meta;
         data_meta <= ps2_data;
         data_sync <= data_meta;
         clk_f_d   <= clk_f;
         // Down-counter runs only while the synced level disagrees with
         // clk_f; any agreeing sample restarts the count.
         if (clk_sync == clk_f) begin
            flt_cnt <= FLT_LOAD;
         end else if (flt_cnt == 4'd0) begin
            clk_f   <= clk_sync;
            flt_cnt <= FLT_LOAD;
         end else begin
            flt_cnt <= flt_cnt - 4'd1;
         end
      end
   end

   assign fall    = clk_f_d & ~clk_f;
   assign timeout = (state != IDLE) && (tmo_cnt == '0) && !fall;

   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         bit_cnt <= 3'd0;
         sr      <= 8'd0;
         par_ok  <= 1'b0;
         tmo_cnt <= '0;
      end else begin
         if (fall) begin
            tmo_cnt <= TMO_LOAD;
         end else if (tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
         end

         if (timeout) begin
            state <= IDLE;
         end else if (fall) begin
            case (state)
               IDLE: begin
                  if (!data_sync) begin
                     state   <= DATA;
                     bit_cnt <= 3'd0;
                  end
               end
               DATA: begin
                  sr      <= {data_sync, sr[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  par_ok <= (^sr) ^ data_sync;
                  state  <= STOP;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Combinational so the top level can register its outputs exactly one
   // cycle after the stop-bit edge.
   assign rx_byte    = sr;
   assign byte_valid = fall && (state == STOP) && data_sync && par_ok;
   assign frame_err  = timeout || (fall && (state == STOP) && !(data_sync && par_ok));

endmodule

// File: rtl/ps2_direction_decoder.sv
// ps2_direction_decoder -- PS/2 keyboard front end for the snake game.
// Decodes make/break codes with E0/F0 prefixes and turns arrow keys into a
// direction command plus a held-key mask.
// Build option: PS2_WASD_EN also maps non-extended W/A/S/D onto the same
// directions and keys_held bits.
// Ports:
//   clk_pixel, rst_n   25 MHz pixel clock / async active-low reset
//   ps2_clk, ps2_data  raw keyboard pins
//   scan_code/ext/break, scan_valid   last non-prefix byte and its prefixes
//   frame_err          pulse on a bad or abandoned frame
//   dir, dir_valid     last pressed direction, pulse on every make
//   keys_held          {up, right, down, left} currently pressed
module ps2_direction_decoder
   import ps2_pkg::*;
#(
   parameter int C_filter_len     = 8,
   parameter int C_timeout_cycles = 5000
) (
   input  logic       clk_pixel,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] scan_code,
   output logic       scan_valid,
   output logic       scan_ext,
   output logic       scan_break,
   output logic       frame_err,
   output logic [1:0] dir,
   output logic       dir_valid,
   output logic [3:0] keys_held
);

   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_err;
   logic       ext_pend, brk_pend;
   dir_map_t   hit_map;

   ps2_rx_frame #(
      .C_filter_len    (C_filter_len),
      .C_timeout_cycles(C_timeout_cycles)
   ) u_rx (
      .clk_pixel (clk_pixel),
      .rst_n     (rst_n),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .rx_byte   (rx_byte),
      .byte_valid(rx_valid),
      .frame_err (rx_err)
   );

   assign hit_map = map_dir(ext_pend, rx_byte);

   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         scan_code  <= 8'd0;
         scan_valid <= 1'b0;
         scan_ext   <= 1'b0;
         scan_break <= 1'b0;
         frame_err  <= 1'b0;
         dir        <= DIR_UP;
         dir_valid  <= 1'b0;
         keys_held  <= 4'd0;
         ext_pend   <= 1'b0;
         brk_pend   <= 1'b0;
      end else begin
         scan_valid <= 1'b0;
         dir_valid  <= 1'b0;
         frame_err  <= 1'b0;
         if (rx_err) begin
            frame_err <= 1'b1;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
         end else if (rx_valid) begin
            if (rx_byte == SC_EXT) begin
               ext_pend <= 1'b1;
            end else if (rx_byte == SC_BRK) begin
               brk_pend <= 1'b1;
            end else begin
               scan_code  <= rx_byte;
               scan_ext   <= ext_pend;
               scan_break <= brk_pend;
               scan_valid <= 1'b1;
               ext_pend   <= 1'b0;
               brk_pend   <= 1'b0;
               if (hit_map.hit) begin
                  if (brk_pend) begin
                     keys_held <= keys_held & ~key_mask(hit_map.code);
                  end else begin
                     dir       <= hit_map.code;
                     keys_held <= keys_held | key_mask(hit_map.code);
                     dir_valid <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_direction_decoder.sv
module tb_ps2_direction_decoder;

   logic       clk_pixel = 1'b0;
   logic       rst_n     = 1'b0;
   logic       ps2_clk   = 1'b1;
   logic       ps2_data  = 1'b1;
   logic [7:0] scan_code;
   logic       scan_valid, scan_ext, scan_break, frame_err, dir_valid;
   logic [1:0] dir;
   logic [3:0] keys_held;

   ps2_direction_decoder #(
      .C_filter_len    (8),
      .C_timeout_cycles(5000)
   ) dut (
      .clk_pixel (clk_pixel),
      .rst_n     (rst_n),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .scan_code (scan_code),
      .scan_valid(scan_valid),
      .scan_ext  (scan_ext),
      .scan_break(scan_break),
      .frame_err (frame_err),
      .dir       (dir),
      .dir_valid (dir_valid),
      .keys_held (keys_held)
   );

   always #20 clk_pixel = ~clk_pixel;

   int cyc = 0;
   always @(posedge clk_pixel) cyc++;

   typedef struct {
      bit       sv;
      bit       fe;
      bit       tmo;
      bit       dv;
      bit [7:0] code;
      bit       ext;
      bit       brk;
      bit [1:0] dir;
      bit [3:0] keys;
   } ev_t;

   ev_t exp_q[$];
   int  n_tests = 0;
   int  n_fail  = 0;

   // Model state: pending prefixes and the key/direction picture.
   bit       m_ext, m_brk;
   bit [1:0] m_dir;
   bit [3:0] m_keys;
   // Values the DUT outputs must currently show.
   bit [1:0] cur_dir;
   bit [3:0] cur_keys;

   int       ev_seen = 0, sv_seen = 0, dv_seen = 0, fe_seen = 0;
   bit [7:0] last_code;
   bit       last_ext, last_brk;
   int       last_fall_cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit [3:0] dir_mask(input bit [1:0] d);
      case (d)
         2'd0:    return 4'b1000;
         2'd1:    return 4'b0100;
         2'd2:    return 4'b0010;
         default: return 4'b0001;
      endcase
   endfunction

   // -1 when the code is not a direction key in this context.
   function automatic int dir_of(input bit ext, input bit [7:0] c);
      if (ext) begin
         if (c == 8'h75) return 0;
         if (c == 8'h74) return 1;
         if (c == 8'h72) return 2;
         if (c == 8'h6B) return 3;
      end
`ifdef PS2_WASD_EN
      else begin
         if (c == 8'h1D) return 0;
         if (c == 8'h23) return 1;
         if (c == 8'h1B) return 2;
         if (c == 8'h1C) return 3;
      end
`endif
      return -1;
   endfunction

   task automatic model_byte(input bit [7:0] b, input bit err, input bit tmo);
      ev_t e;
      int  d;
      e = '{default: 0};
      if (err) begin
         e.fe = 1; e.tmo = tmo;
         m_ext = 0; m_brk = 0;
         e.dir = m_dir; e.keys = m_keys;
         exp_q.push_back(e);
      end else if (b == 8'hE0) begin
         m_ext = 1;
      end else if (b == 8'hF0) begin
         m_brk = 1;
      end else begin
         d = dir_of(m_ext, b);
         if (d >= 0) begin
            if (m_brk) begin
               m_keys = m_keys & ~dir_mask(2'(d));
            end else begin
               m_dir  = 2'(d);
               m_keys = m_keys | dir_mask(2'(d));
               e.dv   = 1;
            end
         end
         e.sv = 1; e.code = b; e.ext = m_ext; e.brk = m_brk;
         e.dir = m_dir; e.keys = m_keys;
         exp_q.push_back(e);
         m_ext = 0; m_brk = 0;
      end
   endtask

   task automatic model_reset();
      m_ext = 0; m_brk = 0; m_dir = 0; m_keys = 0;
      cur_dir = 0; cur_keys = 0;
      exp_q.delete();
   endtask

   // Compare process: every cycle out of reset.
   always @(negedge clk_pixel) begin
      ev_t e;
      int  lat;
      if (rst_n) begin
         if (scan_valid || frame_err || dir_valid) begin
            ev_seen++;
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_event: sv=%0b fe=%0b dv=%0b code=0x%0h, none expected (cycle %0d)",
                        scan_valid, frame_err, dir_valid, scan_code, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("scan_valid", scan_valid, e.sv);
               chk("frame_err", frame_err, e.fe);
               chk("dir_valid", dir_valid, e.dv);
               if (e.sv) begin
                  chk("scan_code", scan_code, e.code);
                  chk("scan_ext", scan_ext, e.ext);
                  chk("scan_break", scan_break, e.brk);
               end
               if (e.tmo) begin
                  lat = cyc - last_fall_cyc;
                  n_tests++;
                  if (lat < 5000 || lat > 5020) begin
                     n_fail++;
                     $display("FAIL timeout_latency: got %0d cycles after last edge, required 5000..5020", lat);
                  end
               end
               cur_dir  = e.dir;
               cur_keys = e.keys;
            end
            if (scan_valid) begin
               sv_seen++;
               last_code = scan_code; last_ext = scan_ext; last_brk = scan_break;
            end
            if (dir_valid) dv_seen++;
            if (frame_err) fe_seen++;
         end
         chk("dir", dir, cur_dir);
         chk("keys_held", keys_held, cur_keys);
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk_pixel);
   endtask

   task automatic ps2_bit(input bit b, input int hp);
      ps2_data = b;
      wait_cyc(hp);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      wait_cyc(hp);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input bit [7:0] b, input bit bad_par, input bit bad_stop, input int hp);
      model_byte(b, bad_par | bad_stop, 1'b0);
      ps2_bit(1'b0, hp);
      for (int i = 0; i < 8; i++) ps2_bit(b[i], hp);
      ps2_bit((~^b) ^ bad_par, hp);
      ps2_bit(~bad_stop, hp);
      ps2_data = 1'b1;
      wait_cyc(hp + 15);
   endtask

   initial begin
      int       hp, sv0, dv0, fe0, ev0, r, gap;
      bit [7:0] b;
      bit       bp, bs;

      model_reset();
      hp = 20;
      wait_cyc(5);
      chk("rst_scan_code", scan_code, 8'h00);
      chk("rst_scan_valid", scan_valid, 1'b0);
      chk("rst_frame_err", frame_err, 1'b0);
      chk("rst_dir", dir, 2'b00);
      chk("rst_keys_held", keys_held, 4'b0000);
      rst_n = 1'b1;
      wait_cyc(20);

      // 1: up arrow make
      sv0 = sv_seen; dv0 = dv_seen;
      send_frame(8'hE0, 0, 0, hp);
      send_frame(8'h75, 0, 0, hp);
      chk("t1_scan_count", sv_seen - sv0, 1);
      chk("t1_code", last_code, 8'h75);
      chk("t1_ext", last_ext, 1'b1);
      chk("t1_brk", last_brk, 1'b0);
      chk("t1_dir", dir, 2'b00);
      chk("t1_dir_valid_count", dv_seen - dv0, 1);
      chk("t1_keys_held", keys_held, 4'b1000);

      // 2: up arrow break
      dv0 = dv_seen;
      send_frame(8'hE0, 0, 0, hp);
      send_frame(8'hF0, 0, 0, hp);
      send_frame(8'h75, 0, 0, hp);
      chk("t2_ext", last_ext, 1'b1);
      chk("t2_brk", last_brk, 1'b1);
      chk("t2_keys_held", keys_held, 4'b0000);
      chk("t2_dir", dir, 2'b00);
      chk("t2_dir_valid_count", dv_seen - dv0, 0);

      // 3: parity error drops the pending E0
      sv0 = sv_seen; fe0 = fe_seen; dv0 = dv_seen;
      send_frame(8'hE0, 0, 0, hp);
      send_frame(8'h6B, 1, 0, hp);
      chk("t3_frame_err_count", fe_seen - fe0, 1);
      chk("t3_scan_count", sv_seen - sv0, 0);
      chk("t3_keys_held", keys_held, 4'b0000);
      send_frame(8'h6B, 0, 0, hp);
      chk("t3_bare_ext", last_ext, 1'b0);
      chk("t3_bare_dir", dir, 2'b00);
      chk("t3_dir_valid_count", dv_seen - dv0, 0);

      // 4: partial frame times out
      fe0 = fe_seen;
      model_byte(8'h00, 1'b1, 1'b1);
      ps2_bit(1'b0, hp);
      for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)), hp);
      ps2_data = 1'b1;
      wait_cyc(5100);
      chk("t4_frame_err_count", fe_seen - fe0, 1);
      send_frame(8'h1C, 0, 0, hp);
      chk("t4_code", last_code, 8'h1C);
`ifdef PS2_WASD_EN
      chk("t4_dir", dir, 2'b11);
      chk("t4_keys_held", keys_held, 4'b0001);
`else
      chk("t4_dir", dir, 2'b00);
      chk("t4_keys_held", keys_held, 4'b0000);
`endif

      // 5: short clock glitch with data low
      ev0 = ev_seen;
      ps2_data = 1'b0;
      wait_cyc(5);
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(40);
      ps2_data = 1'b1;
      wait_cyc(20);
      send_frame(8'h29, 0, 0, hp);
      chk("t5_glitch_events", ev_seen - ev0, 1);
      chk("t5_code_after_glitch", last_code, 8'h29);

      // 6: reset in the middle of a frame
      send_frame(8'hE0, 0, 0, hp);
      send_frame(8'h72, 0, 0, hp);
      chk("t6_queue_empty", exp_q.size(), 0);
      ps2_bit(1'b0, hp);
      for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1), hp);
      ps2_data = 1'b1;
      rst_n = 1'b0;
      model_reset();
      wait_cyc(1);
      chk("t6_rst_keys_held", keys_held, 4'b0000);
      chk("t6_rst_scan_code", scan_code, 8'h00);
      chk("t6_rst_dir", dir, 2'b00);
      chk("t6_rst_strobes", {scan_valid, scan_ext, scan_break, frame_err, dir_valid}, 5'b0);
      wait_cyc(1);
      rst_n = 1'b1;
      wait_cyc(20);
      dv0 = dv_seen;
      send_frame(8'hE0, 0, 0, hp);
      send_frame(8'h74, 0, 0, hp);
      chk("t6_dir", dir, 2'b01);
      chk("t6_dir_valid_count", dv_seen - dv0, 1);
      chk("t6_keys_held", keys_held, 4'b0100);

      // Random traffic
      for (int n = 0; n < 60; n++) begin
         r = $urandom_range(0, 99);
         if (r < 20)      b = 8'hE0;
         else if (r < 35) b = 8'hF0;
         else if (r < 75) begin
            case ($urandom_range(0, 7))
               0: b = 8'h75; 1: b = 8'h74; 2: b = 8'h72; 3: b = 8'h6B;
               4: b = 8'h1D; 5: b = 8'h23; 6: b = 8'h1B; default: b = 8'h1C;
            endcase
         end else b = 8'($urandom_range(0, 255));
         r  = $urandom_range(0, 99);
         bp = (r < 8);
         bs = (r >= 8 && r < 12);
         hp = $urandom_range(14, 40);
         send_frame(b, bp, bs, hp);
         gap = $urandom_range(0, 40);
         wait_cyc(gap);
      end

      for (int i = 0; i < 500 && exp_q.size() != 0; i++) wait_cyc(1);
      chk("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
